// File: rtl/vga_sync_output.sv
// VGA timing generator: free-running h/v counters, one stage of decode (x/y, sync, blank),
// one stage of colour registration so RGB, sync and blank leave the block aligned.
module vga_sync_output #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        frame_tick
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] HVisEnd    = 12'(H_VISIBLE);
  localparam logic [11:0] HSyncStart = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HSyncEnd   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] HLast      = 12'(HTotal - 1);
  localparam logic [11:0] VVisEnd    = 12'(V_VISIBLE);
  localparam logic [11:0] VSyncStart = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VSyncEnd   = 12'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [11:0] VLast      = 12'(VTotal - 1);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        h_wrap;
  logic        active_d, active_q;
  logic        hs_d, hs_q;
  logic        vs_d, vs_q;
  logic [11:0] x_d, y_d;
  logic        frame_tick_d;
  logic [3:0]  r_d, g_d, b_d;

  always_comb begin
    h_wrap  = (h_cnt_q == HLast);
    h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == VLast) ? 12'd0 : v_cnt_q + 12'd1;
    end

    // Stage-1 decode of the current counter pair
    active_d     = (h_cnt_q < HVisEnd) && (v_cnt_q < VVisEnd);
    x_d          = active_d ? h_cnt_q + 12'd1 : 12'd0;
    y_d          = active_d ? v_cnt_q + 12'd1 : 12'd0;
    hs_d         = !((h_cnt_q >= HSyncStart) && (h_cnt_q < HSyncEnd));
    vs_d         = !((v_cnt_q >= VSyncStart) && (v_cnt_q < VSyncEnd));
    frame_tick_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

    // Stage 2: colour arrives combinationally from x/y, gated by the matching active bit
    r_d = active_q ? {4{color[2]}} : 4'h0;
    g_d = active_q ? {4{color[1]}} : 4'h0;
    b_d = active_q ? {4{color[0]}} : 4'h0;
  end

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      h_cnt_q     <= 12'd0;
      v_cnt_q     <= 12'd0;
      x           <= 12'd0;
      y           <= 12'd0;
      active_q    <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      frame_tick  <= 1'b0;
      VGA_R       <= 4'h0;
      VGA_G       <= 4'h0;
      VGA_B       <= 4'h0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      x           <= x_d;
      y           <= y_d;
      active_q    <= active_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      frame_tick  <= frame_tick_d;
      VGA_R       <= r_d;
      VGA_G       <= g_d;
      VGA_B       <= b_d;
      VGA_HS      <= hs_q;
      VGA_VS      <= vs_q;
      VGA_BLANK_N <= active_q;
    end
  end

endmodule
